// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly downstream of the program counter.
// It fetches the word at pc_adrs over a req/ack memory port, holds it in the
// instruction register (IR) and offers it to decode with valid/ready. The PC
// is steered back through next_adrs/en_pc: a +1 advance after each fetch, or a
// redirect to a branch target from execute.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   Defined   - a request left unacknowledged for TIMEOUT_CYC cycles raises a
//               sticky fetch_err and parks the unit in S_IDLE until reset.
//   Undefined - no watchdog; fetch_err is tied to 0.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-low reset
//   pc_adrs      in   AW  current PC value
//   next_adrs    out  AW  next PC value (combinational, valid with en_pc)
//   en_pc        out  1   PC load enable, single-cycle pulse (combinational)
//   mem_req      out  1   instruction memory read request
//   mem_adrs     out  AW  memory address (pc_adrs while mem_req, else 0)
//   mem_ack      in   1   memory done, mem_rdata valid in the same cycle
//   mem_rdata    in   IW  memory read data
//   instr_out    out  IW  fetched instruction (IR)
//   instr_valid  out  1   instr_out valid to decode
//   instr_ready  in   1   decode accepts instr_out
//   br_valid     in   1   branch/redirect pulse from execute
//   br_target    in   AW  redirect address
//   fetch_err    out  1   sticky fetch timeout flag
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int unsigned AW          = 8,
   parameter int unsigned IW          = 16,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc_adrs,
   output logic [AW-1:0] next_adrs,
   output logic          en_pc,
   output logic          mem_req,
   output logic [AW-1:0] mem_adrs,
   input  logic          mem_ack,
   input  logic [IW-1:0] mem_rdata,
   output logic [IW-1:0] instr_out,
   output logic          instr_valid,
   input  logic          instr_ready,
   input  logic          br_valid,
   input  logic [AW-1:0] br_target,
   output logic          fetch_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_VALID = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] ir_q, ir_d;
   logic          br_pend_q, br_pend_d;
   logic [AW-1:0] br_tgt_q, br_tgt_d;
   // One-cycle request bubble after a redirect inside S_REQ: the PC loads on
   // the redirect edge, so the new request starts from a clean cycle.
   logic          gap_q, gap_d;

   logic          halt;     // unit parked after a timeout
   logic          timeout;  // current request reaches the timeout limit

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   // Counts open-request cycles without an ack; any other cycle clears it, so
   // every fresh entry into a request starts from zero.
   always_comb begin
      cnt_d   = '0;
      timeout = 1'b0;
      if (state_q == S_REQ && !gap_q && !mem_ack) begin
         cnt_d   = cnt_q + CW'(1);
         timeout = (cnt_q == CW'(TIMEOUT_CYC - 1));
      end
      err_d = err_q | timeout;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign halt      = err_q;
   assign fetch_err = err_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = |TIMEOUT_CYC;

   assign timeout   = 1'b0;
   assign halt      = 1'b0;
   assign fetch_err = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      br_pend_d   = br_pend_q;
      br_tgt_d    = br_tgt_q;
      gap_d       = 1'b0;
      en_pc       = 1'b0;
      next_adrs   = '0;
      mem_req     = 1'b0;
      instr_valid = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!halt) begin
               state_d = S_REQ;
               // rst gating keeps en_pc/next_adrs at 0 while reset is held.
               if (br_valid && rst) begin
                  en_pc     = 1'b1;
                  next_adrs = br_target;
               end
            end
         end

         S_REQ: begin
            mem_req = !gap_q;
            if (gap_q) begin
               // No request open: just record a branch, latest wins.
               if (br_valid) begin
                  br_pend_d = 1'b1;
                  br_tgt_d  = br_target;
               end
            end else if (mem_ack) begin
               if (br_valid) begin
                  // Branch in the ack cycle beats both the data and any
                  // older pending target.
                  en_pc     = 1'b1;
                  next_adrs = br_target;
                  br_pend_d = 1'b0;
                  gap_d     = 1'b1;
               end else if (br_pend_q) begin
                  en_pc     = 1'b1;
                  next_adrs = br_tgt_q;
                  br_pend_d = 1'b0;
                  gap_d     = 1'b1;
               end else begin
                  ir_d      = mem_rdata;
                  en_pc     = 1'b1;
                  next_adrs = pc_adrs + AW'(1);
                  state_d   = S_VALID;
               end
            end else begin
               if (br_valid) begin
                  br_pend_d = 1'b1;
                  br_tgt_d  = br_target;
               end
               if (timeout) begin
                  state_d   = S_IDLE;
                  br_pend_d = 1'b0;
               end
            end
         end

         S_VALID: begin
            instr_valid = !br_valid;
            if (br_valid) begin
               // Squash: the IR content is dropped even if decode is ready.
               en_pc     = 1'b1;
               next_adrs = br_target;
               state_d   = S_REQ;
            end else if (instr_ready) begin
               state_d = S_REQ;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_adrs  = mem_req ? pc_adrs : '0;
   assign instr_out = ir_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         ir_q      <= '0;
         br_pend_q <= 1'b0;
         br_tgt_q  <= '0;
         gap_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         br_pend_q <= br_pend_d;
         br_tgt_q  <= br_tgt_d;
         gap_q     <= gap_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A small PC register lives in the bench and
// loads next_adrs whenever en_pc pulses, resetting to pc_init. Inputs are
// driven 1 ns after the rising edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [7:0]  pc_adrs;
   logic [7:0]  next_adrs;
   logic        en_pc;
   logic        mem_req;
   logic [7:0]  mem_adrs;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] instr_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        br_valid;
   logic [7:0]  br_target;
   logic        fetch_err;

   logic [7:0]  pc_init;
   int          checks;
   int          errors;

   fetch_unit #(
      .AW          (8),
      .IW          (16),
      .TIMEOUT_CYC (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_adrs     (pc_adrs),
      .next_adrs   (next_adrs),
      .en_pc       (en_pc),
      .mem_req     (mem_req),
      .mem_adrs    (mem_adrs),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .fetch_err   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench-side PC register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc_adrs <= pc_init;
      else if (en_pc) pc_adrs <= next_adrs;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      pc_init     = 8'h00;
      rst         = 1'b1;
      mem_ack     = 1'b0;
      mem_rdata   = 16'h0000;
      instr_ready = 1'b0;
      br_valid    = 1'b0;
      br_target   = 8'h00;
      #1 rst = 1'b0;
      #1;
      // Reset state
      chk("rst_mem_req", mem_req, 0);
      chk("rst_en_pc", en_pc, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_fetch_err", fetch_err, 0);
      chk("rst_next_adrs", next_adrs, 0);
      chk("rst_mem_adrs", mem_adrs, 0);
      chk("rst_instr_out", instr_out, 0);

      // 1: basic fetch at 0x00
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t1_idle_no_req", mem_req, 0);
      tick();
      #1;
      chk("t1_req", mem_req, 1);
      chk("t1_mem_adrs", mem_adrs, 8'h00);
      chk("t1_no_en_pc", en_pc, 0);
      tick();
      mem_ack = 1'b1; mem_rdata = 16'h1234;
      #1;
      chk("t1_en_pc", en_pc, 1);
      chk("t1_next_adrs", next_adrs, 8'h01);
      chk("t1_not_valid_yet", instr_valid, 0);
      tick();
      mem_ack = 1'b0; instr_ready = 1'b1;
      #1;
      chk("t1_valid", instr_valid, 1);
      chk("t1_instr_out", instr_out, 16'h1234);
      chk("t1_valid_no_req", mem_req, 0);
      chk("t1_valid_no_en_pc", en_pc, 0);
      tick();
      instr_ready = 1'b0;
      #1;
      chk("t1_b2b_req", mem_req, 1);
      chk("t1_b2b_adrs", mem_adrs, 8'h01);

      // 3: branch pended during request, ack three cycles later
      br_valid = 1'b1; br_target = 8'h40;
      #1;
      chk("t3_pend_no_en_pc", en_pc, 0);
      tick();
      br_valid = 1'b0;
      #1;
      chk("t3_adrs_stable", mem_adrs, 8'h01);
      tick();
      tick();
      mem_ack = 1'b1; mem_rdata = 16'hBEEF;
      #1;
      chk("t3_en_pc", en_pc, 1);
      chk("t3_next_adrs", next_adrs, 8'h40);
      chk("t3_no_valid", instr_valid, 0);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("t3_gap_no_req", mem_req, 0);
      chk("t3_gap_no_valid", instr_valid, 0);
      tick();
      #1;
      chk("t3_req", mem_req, 1);
      chk("t3_mem_adrs", mem_adrs, 8'h40);
      chk("t3_still_no_valid", instr_valid, 0);

      // 4: branch squashes a valid instruction even with instr_ready
      mem_ack = 1'b1; mem_rdata = 16'h5A5A;
      #1;
      chk("t4_next_adrs_inc", next_adrs, 8'h41);
      tick();
      mem_ack = 1'b0; br_valid = 1'b1; br_target = 8'h80; instr_ready = 1'b1;
      #1;
      chk("t4_squash_valid", instr_valid, 0);
      chk("t4_en_pc", en_pc, 1);
      chk("t4_next_adrs", next_adrs, 8'h80);
      tick();
      br_valid = 1'b0; instr_ready = 1'b0;
      #1;
      chk("t4_req", mem_req, 1);
      chk("t4_mem_adrs", mem_adrs, 8'h80);
      chk("t4_no_valid", instr_valid, 0);

      // Branch and ack in the same cycle: the branch wins (used to reach 0xFF)
      mem_ack = 1'b1; mem_rdata = 16'h0BAD; br_valid = 1'b1; br_target = 8'hFF;
      #1;
      chk("tbr_en_pc", en_pc, 1);
      chk("tbr_next_adrs", next_adrs, 8'hFF);
      tick();
      mem_ack = 1'b0; br_valid = 1'b0;
      #1;
      chk("tbr_gap", mem_req, 0);
      tick();
      #1;
      chk("tbr_mem_adrs", mem_adrs, 8'hFF);
      chk("tbr_no_valid", instr_valid, 0);

      // 2: wrap at 0xFF, then decode stalls for 5 cycles
      mem_ack = 1'b1; mem_rdata = 16'hCAFE;
      #1;
      chk("t2_en_pc", en_pc, 1);
      chk("t2_wrap", next_adrs, 8'h00);
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t2_hold_valid", instr_valid, 1);
         chk("t2_hold_instr", instr_out, 16'hCAFE);
         chk("t2_hold_no_req", mem_req, 0);
         chk("t2_hold_no_en_pc", en_pc, 0);
         tick();
      end
      instr_ready = 1'b1;
      #1;
      chk("t2_valid_at_accept", instr_valid, 1);
      tick();
      instr_ready = 1'b0;
      #1;
      chk("t2_req_after", mem_req, 1);
      chk("t2_mem_adrs", mem_adrs, 8'h00);

      // 5: reset while a request is open, stale ack after release is ignored
      pc_init = 8'h10;
      rst = 1'b0;
      #1;
      chk("t5_mem_req", mem_req, 0);
      chk("t5_mem_adrs", mem_adrs, 0);
      chk("t5_en_pc", en_pc, 0);
      chk("t5_instr_valid", instr_valid, 0);
      chk("t5_instr_out", instr_out, 0);
      chk("t5_next_adrs", next_adrs, 0);
      chk("t5_fetch_err", fetch_err, 0);
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
      tick();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5_idle_no_req", mem_req, 0);
      chk("t5_idle_ack_ignored", en_pc, 0);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("t5_req", mem_req, 1);
      chk("t5_mem_adrs_new", mem_adrs, 8'h10);
      chk("t5_no_valid", instr_valid, 0);

      // Branch seen in S_IDLE right after reset
      rst = 1'b0;
      #1;
      @(negedge clk);
      rst = 1'b1; br_valid = 1'b1; br_target = 8'h22;
      #1;
      chk("tidle_en_pc", en_pc, 1);
      chk("tidle_next_adrs", next_adrs, 8'h22);
      tick();
      br_valid = 1'b0;
      #1;
      chk("tidle_mem_adrs", mem_adrs, 8'h22);

`ifdef FETCH_TIMEOUT_EN
      // 6: no ack for TIMEOUT_CYC=4 request cycles
      for (int i = 0; i < 4; i++) begin
         chk("t6_req_before_to", mem_req, 1);
         chk("t6_no_err_yet", fetch_err, 0);
         tick();
         #1;
      end
      chk("t6_fetch_err", fetch_err, 1);
      chk("t6_no_req", mem_req, 0);
      br_valid = 1'b1; br_target = 8'h55;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t6_br_ignored", en_pc, 0);
         chk("t6_parked_no_req", mem_req, 0);
         chk("t6_err_sticky", fetch_err, 1);
         tick();
      end
      br_valid = 1'b0;
`else
      // Without the watchdog a long wait never raises fetch_err
      for (int i = 0; i < 6; i++) begin
         chk("t6_req_held", mem_req, 1);
         chk("t6_no_err", fetch_err, 0);
         chk("t6_adrs_held", mem_adrs, 8'h22);
         tick();
         #1;
      end
      mem_ack = 1'b1; mem_rdata = 16'h7777;
      #1;
      chk("t6_late_ack_next", next_adrs, 8'h23);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("t6_late_instr", instr_out, 16'h7777);
      chk("t6_late_valid", instr_valid, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
